dec_checker: RTL and testbench

Plaintext checker that reads the decrypted message back out of `dec_memory` after the decrypt stage finishes, and judges whether it is legible text. It is the reader on the port that the decrypt stage writes. It streams the message one byte per clock and stops at the first illegal byte. Its verdict drives key-search control and the LEDs/HEX display. It uses the same start / `task_on` / `fin_strobe` handshake as the other stages.

---
 rtl/dec_checker.sv | 129 ++++++++++++
 tb/tb_dec_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_checker.sv
// Plaintext legibility checker: streams MSG_LEN bytes out of dec_memory and
// reports whether all are lowercase letters or spaces, stopping at the first bad byte.
module dec_checker #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] address,
  output logic       task_on,
  output logic       fin_strobe,
  output logic       done,
  output logic       valid,
  output logic [7:0] bad_index
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);
  localparam logic [8:0] LAST_IDX  = 9'(MSG_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] idx_q, idx_d;
  logic       chk_en_q, chk_en_d;
  logic       task_on_q, task_on_d;
  logic       fin_q, fin_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic [7:0] bad_q, bad_d;
  logic       byte_legal;

  always_comb begin
    byte_legal = (data_in == 8'h20) || ((data_in >= 8'h61) && (data_in <= 8'h7A));
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    chk_en_d  = chk_en_q;
    task_on_d = task_on_q;
    fin_d     = 1'b0;
    done_d    = done_q;
    valid_d   = valid_q;
    bad_d     = bad_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          addr_d    = '0;
          idx_d     = '0;
          chk_en_d  = 1'b0;
          task_on_d = 1'b1;
          done_d    = 1'b0;
          valid_d   = 1'b0;
          bad_d     = '0;
        end
      end

      SCAN: begin
        // data_in lags the issued address by one cycle, so checking starts
        // one cycle after entry while the address runs ahead and saturates.
        chk_en_d = 1'b1;
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + 8'd1;
        end
        if (chk_en_q) begin
          if (!byte_legal || (idx_q == LAST_IDX)) begin
            state_d   = DONE;
            addr_d    = '0;
            chk_en_d  = 1'b0;
            task_on_d = 1'b0;
            fin_d     = 1'b1;
            done_d    = 1'b1;
            valid_d   = byte_legal;
            bad_d     = byte_legal ? 8'd0 : idx_q[7:0];
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      chk_en_q  <= 1'b0;
      task_on_q <= 1'b0;
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      chk_en_q  <= chk_en_d;
      task_on_q <= task_on_d;
      fin_q     <= fin_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      bad_q     <= bad_d;
    end
  end

  assign address    = addr_q;
  assign task_on    = task_on_q;
  assign fin_strobe = fin_q;
  assign done       = done_q;
  assign valid      = valid_q;
  assign bad_index  = bad_q;

endmodule

// File: tb/tb_dec_checker.sv
// Directed bench for dec_checker at MSG_LEN=32 and MSG_LEN=256, each fed by a
// memory model with a registered address and combinational read data.
module tb_dec_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b0;
  logic start32  = 1'b0;
  logic start256 = 1'b0;

  logic [7:0] mem32  [0:31];
  logic [7:0] mem256 [0:255];
  logic [7:0] ra32 = '0;
  logic [7:0] ra256 = '0;
  logic [7:0] din32, din256;

  logic [7:0] addr32, bad32, addr256, bad256;
  logic       ton32, fin32, done32, valid32;
  logic       ton256, fin256, done256, valid256;

  dec_checker #(.MSG_LEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .data_in(din32),
    .address(addr32), .task_on(ton32), .fin_strobe(fin32), .done(done32),
    .valid(valid32), .bad_index(bad32)
  );

  dec_checker #(.MSG_LEN(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .data_in(din256),
    .address(addr256), .task_on(ton256), .fin_strobe(fin256), .done(done256),
    .valid(valid256), .bad_index(bad256)
  );

  always @(posedge clk) begin
    ra32  <= addr32;
    ra256 <= addr256;
  end
  assign din32  = mem32[ra32[4:0]];
  assign din256 = mem256[ra256];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a scan (current cycle is cycle 0) and watches it cycle by cycle.
  // Returns after sampling cycle fin+1, or cycle rst_cyc+2 when a reset is injected.
  task automatic run(input bit sel, input int rst_cyc, input int xs1, input int xs2,
                     output int fin_cyc, output int ton_first, output int ton_last,
                     output int max_addr, output int fin_cnt, output int addr_bad,
                     output int clr_bad);
    int last, ad, bi, exp_ad;
    bit ton, fin, dn, vl;
    last = sel ? 255 : 31;
    fin_cyc = -1; ton_first = -1; ton_last = -1;
    max_addr = 0; fin_cnt = 0; addr_bad = 0; clr_bad = 0;
    if (sel) start256 = 1'b1; else start32 = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start32 = 1'b0; start256 = 1'b0; rst_n = 1'b1;
      ton = sel ? ton256  : ton32;
      fin = sel ? fin256  : fin32;
      dn  = sel ? done256 : done32;
      vl  = sel ? valid256 : valid32;
      ad  = sel ? int'(addr256) : int'(addr32);
      bi  = sel ? int'(bad256)  : int'(bad32);
      if (ton) begin
        if (ton_first < 0) ton_first = cyc;
        ton_last = cyc;
        exp_ad = (cyc - 1 < last) ? cyc - 1 : last;
        if (ad != exp_ad) addr_bad++;
      end
      if (ad > max_addr) max_addr = ad;
      if (fin) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      if (cyc == 1 && (dn || vl || bi != 0)) clr_bad++;
      if (cyc == xs1 || cyc == xs2) begin
        if (sel) start256 = 1'b1; else start32 = 1'b1;
      end
      if (cyc == rst_cyc) rst_n = 1'b0;
      if (fin_cyc > 0 && cyc == fin_cyc + 1) break;
      if (rst_cyc > 0 && cyc == rst_cyc + 2) break;
    end
  endtask

  task automatic load_attack();
    string s;
    s = "attack at dawn";
    for (int i = 0; i < 32; i++) mem32[i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, t0, t1, ma, fc, ab, cb;
    load_attack();
    for (int i = 0; i < 256; i++) mem256[i] = 8'h7A;

    // Reset and idle with no start
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle32_outs", int'({addr32, ton32, fin32, done32, valid32, bad32}), 0);
    end
    chk("idle256_outs", int'({addr256, ton256, fin256, done256, valid256, bad256}), 0);

    // A: all legal text
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("A_fin_cyc", f, 34);
    chk("A_ton_first", t0, 1);
    chk("A_ton_last", t1, 33);
    chk("A_fin_cnt", fc, 1);
    chk("A_addr_seq", ab, 0);
    chk("A_max_addr", ma, 31);
    chk("A_valid", int'(valid32), 1);
    chk("A_bad_index", int'(bad32), 0);
    chk("A_done_held", int'(done32), 1);

    // B: byte 5 = 'A', started back-to-back
    for (int i = 0; i < 32; i++) mem32[i] = 8'h61;
    mem32[5] = 8'h41;
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("B_clear_on_start", cb, 0);
    chk("B_fin_cyc", f, 8);
    chk("B_ton_last", t1, 7);
    chk("B_max_addr", ma, 6);
    chk("B_addr_seq", ab, 0);
    chk("B_valid", int'(valid32), 0);
    chk("B_bad_index", int'(bad32), 5);

    // C: byte 0 = '{'
    mem32[5] = 8'h61;
    mem32[0] = 8'h7B;
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("C_clear_on_start", cb, 0);
    chk("C_fin_cyc", f, 3);
    chk("C_ton_last", t1, 2);
    chk("C_valid", int'(valid32), 0);
    chk("C_bad_index", int'(bad32), 0);
    chk("C_done_held", int'(done32), 1);

    // D: last byte = '`'
    mem32[0] = 8'h61;
    mem32[31] = 8'h60;
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("D_fin_cyc", f, 34);
    chk("D_valid", int'(valid32), 0);
    chk("D_bad_index", int'(bad32), 31);

    // E: only boundary legal values
    for (int i = 0; i < 32; i++) mem32[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? 8'h61 : 8'h7A);
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("E_clear_on_start", cb, 0);
    chk("E_fin_cyc", f, 34);
    chk("E_valid", int'(valid32), 1);
    chk("E_bad_index", int'(bad32), 0);

    // F: MSG_LEN=256, all 'z'
    run(1'b1, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("F_fin_cyc", f, 258);
    chk("F_ton_last", t1, 257);
    chk("F_max_addr", ma, 255);
    chk("F_addr_seq", ab, 0);
    chk("F_valid", int'(valid256), 1);
    chk("F_bad_index", int'(bad256), 0);

    // G: extra start pulses mid-scan
    load_attack();
    run(1'b0, 0, 4, 20, f, t0, t1, ma, fc, ab, cb);
    chk("G_fin_cyc", f, 34);
    chk("G_fin_cnt", fc, 1);
    chk("G_ton_last", t1, 33);
    chk("G_valid", int'(valid32), 1);

    // H: reset in cycle 10 aborts, then a fresh run completes
    run(1'b0, 10, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("H_abort_fin_cnt", fc, 0);
    chk("H_abort_ton_last", t1, 10);
    chk("H_abort_outs", int'({addr32, ton32, fin32, done32, valid32, bad32}), 0);
    run(1'b0, 0, 0, 0, f, t0, t1, ma, fc, ab, cb);
    chk("H_rerun_fin_cyc", f, 34);
    chk("H_rerun_fin_cnt", fc, 1);
    chk("H_rerun_valid", int'(valid32), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
